// File: rtl/id_stage_if.sv
// Fetch/writeback/ID-EX signal bundle for the decode stage.
interface id_stage_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned RW = 5;

  logic [XLEN-1:0] ir_in;
  logic [XLEN-1:0] npc_in;
  logic            in_valid;
  logic            flush;
  logic            wb_en;
  logic [RW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] npc_out;
  logic [XLEN-1:0] ir_out;
  logic [XLEN-1:0] a_out;
  logic [XLEN-1:0] b_out;
  logic [XLEN-1:0] imm_out;
  logic [2:0]      itype_out;
  logic [RW-1:0]   dest_out;
  logic            valid_out;
  logic            stall;
  logic            halted;

  modport master (
    output ir_in, npc_in, in_valid, flush, wb_en, wb_addr, wb_data,
    input  npc_out, ir_out, a_out, b_out, imm_out, itype_out, dest_out,
           valid_out, stall, halted
  );

  modport slave (
    input  ir_in, npc_in, in_valid, flush, wb_en, wb_addr, wb_data,
    output npc_out, ir_out, a_out, b_out, imm_out, itype_out, dest_out,
           valid_out, stall, halted
  );
endinterface

// File: rtl/id_stage.sv
// MIPS32-style instruction decode: register file, decode, load-use
// hazard detection and the ID/EX pipeline register.
module id_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic        clk1,
  input  logic        rst,
  id_stage_if.slave   bus
);
  localparam int unsigned AW = 5;

  typedef enum logic [2:0] {
    IT_NOP    = 3'd0,
    IT_RR     = 3'd1,
    IT_RM     = 3'd2,
    IT_LOAD   = 3'd3,
    IT_STORE  = 3'd4,
    IT_BRANCH = 3'd5,
    IT_JUMP   = 3'd6,
    IT_HALT   = 3'd7
  } itype_e;

  typedef struct packed {
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    itype_e          itype;
    logic [AW-1:0]   dest;
    logic            valid;
  } idex_t;

  logic [XLEN-1:0] rf [NREG];
  idex_t           idex_q, idex_d;
  logic            halted_q, set_halt;

  logic [5:0]      op;
  logic [AW-1:0]   rs, rt, rd;
  itype_e          dec_itype;
  logic            illegal, reads_rs, reads_rt;
  logic [XLEN-1:0] dec_imm, rs_val, rt_val;
  logic [AW-1:0]   dec_dest;
  logic            stall_c;

  assign op = bus.ir_in[31:26];
  assign rs = bus.ir_in[25:21];
  assign rt = bus.ir_in[20:16];
  assign rd = bus.ir_in[15:11];

  // Register file: r0 is never written, so it always reads back as zero.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != '0) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Combinational reads with same-cycle writeback bypass.
  always_comb begin
    rs_val = rf[rs];
    rt_val = rf[rt];
    if (bus.wb_en && bus.wb_addr == rs) rs_val = bus.wb_data;
    if (bus.wb_en && bus.wb_addr == rt) rt_val = bus.wb_data;
    if (rs == '0) rs_val = '0;
    if (rt == '0) rt_val = '0;
  end

  // Opcode decode.
  always_comb begin
    dec_itype = IT_NOP;
    illegal   = 1'b0;
    case (op)
      6'b000000:                                dec_itype = IT_RR;
      6'b001000, 6'b001010, 6'b001100, 6'b001101: dec_itype = IT_RM;
      6'b100011:                                dec_itype = IT_LOAD;
      6'b101011:                                dec_itype = IT_STORE;
      6'b000100, 6'b000101:                     dec_itype = IT_BRANCH;
      6'b000010:                                dec_itype = IT_JUMP;
      6'b111111:                                dec_itype = IT_HALT;
      default:                                  illegal   = 1'b1;
    endcase

    dec_imm = (dec_itype == IT_JUMP) ? XLEN'(bus.ir_in[25:0])
                                     : XLEN'($signed(bus.ir_in[15:0]));

    dec_dest = '0;
    if (dec_itype == IT_RR) dec_dest = rd;
    else if (dec_itype == IT_RM || dec_itype == IT_LOAD) dec_dest = rt;

    reads_rs = !illegal && dec_itype != IT_JUMP && dec_itype != IT_HALT;
    reads_rt = dec_itype == IT_RR || dec_itype == IT_STORE;
  end

  // Load-use hazard against the load currently sitting in ID/EX.
  always_comb begin
    stall_c = 1'b0;
    if (bus.in_valid && idex_q.valid && idex_q.itype == IT_LOAD &&
        idex_q.dest != '0 && !bus.flush && !halted_q) begin
      stall_c = (reads_rs && idex_q.dest == rs) ||
                (reads_rt && idex_q.dest == rt);
    end
  end

  // ID/EX next value; every blocking condition collapses to a bubble.
  always_comb begin
    idex_d   = '0;
    set_halt = 1'b0;
    if (!bus.flush && !halted_q && !stall_c && bus.in_valid && !illegal) begin
      idex_d.npc   = bus.npc_in;
      idex_d.ir    = bus.ir_in;
      idex_d.a     = reads_rs ? rs_val : '0;
      idex_d.b     = reads_rt ? rt_val : '0;
      idex_d.imm   = dec_imm;
      idex_d.itype = dec_itype;
      idex_d.dest  = dec_dest;
      idex_d.valid = 1'b1;
      set_halt     = (dec_itype == IT_HALT);
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      idex_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      idex_q   <= idex_d;
      halted_q <= halted_q | set_halt;
    end
  end

  assign bus.npc_out   = idex_q.npc;
  assign bus.ir_out    = idex_q.ir;
  assign bus.a_out     = idex_q.a;
  assign bus.b_out     = idex_q.b;
  assign bus.imm_out   = idex_q.imm;
  assign bus.itype_out = idex_q.itype;
  assign bus.dest_out  = idex_q.dest;
  assign bus.valid_out = idex_q.valid;
  assign bus.halted    = halted_q;
  assign bus.stall     = stall_c;
endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage with hand-computed expectations.
module tb_id_stage;
  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  int   total = 0;
  int   bad   = 0;

  id_stage_if #(.XLEN(32)) bus ();

  id_stage dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus.slave)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic issue(input logic [31:0] ir, input logic [31:0] npc);
    bus.ir_in    = ir;
    bus.npc_in   = npc;
    bus.in_valid = 1'b1;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en   = en;
    bus.wb_addr = addr;
    bus.wb_data = data;
  endtask

  initial begin
    bus.ir_in = '0; bus.npc_in = '0; bus.in_valid = 1'b0; bus.flush = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    #12;
    chk("rst_valid",  32'(bus.valid_out), 32'h0);
    chk("rst_halted", 32'(bus.halted),    32'h0);
    chk("rst_a",      bus.a_out,          32'h0);
    chk("rst_itype",  32'(bus.itype_out), 32'h0);
    rst = 1'b0;

    // r5 = 0x1234, then add r3,r5,r0
    step();
    wb(1'b1, 5'd5, 32'h0000_1234);
    step();
    wb(1'b0, 5'd0, 32'h0);
    issue(32'h00A0_1820, 32'h0000_0104);
    step();
    chk("rr_a",     bus.a_out,          32'h0000_1234);
    chk("rr_b",     bus.b_out,          32'h0);
    chk("rr_dest",  32'(bus.dest_out),  32'd3);
    chk("rr_itype", 32'(bus.itype_out), 32'd1);
    chk("rr_valid", 32'(bus.valid_out), 32'd1);
    chk("rr_npc",   bus.npc_out,        32'h0000_0104);
    chk("rr_imm",   bus.imm_out,        32'h0000_1820);

    // addi r8,r7,-4 with r7 written the same cycle
    wb(1'b1, 5'd7, 32'hDEAD_BEEF);
    issue(32'h20E8_FFFC, 32'h0000_0108);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("wt_a",     bus.a_out,          32'hDEAD_BEEF);
    chk("wt_imm",   bus.imm_out,        32'hFFFF_FFFC);
    chk("wt_dest",  32'(bus.dest_out),  32'd8);
    chk("wt_itype", 32'(bus.itype_out), 32'd2);
    chk("wt_ir",    bus.ir_out,         32'h20E8_FFFC);

    // lw r2,0(r1) then add r4,r2,r3
    issue(32'h8C22_0000, 32'h0000_010C);
    step();
    chk("lw_itype", 32'(bus.itype_out), 32'd3);
    chk("lw_dest",  32'(bus.dest_out),  32'd2);
    issue(32'h0043_2020, 32'h0000_0110);
    wb(1'b1, 5'd2, 32'h0000_ABCD);
    #1;
    chk("lu_stall", 32'(bus.stall), 32'd1);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("lu_bubble",  32'(bus.valid_out), 32'd0);
    chk("lu_bub_typ", 32'(bus.itype_out), 32'd0);
    chk("lu_unstall", 32'(bus.stall),     32'd0);
    step();
    chk("lu_valid", 32'(bus.valid_out), 32'd1);
    chk("lu_a",     bus.a_out,          32'h0000_ABCD);
    chk("lu_b",     bus.b_out,          32'h0);
    chk("lu_dest",  32'(bus.dest_out),  32'd4);

    // lw r0,0(r1) then add r10,r0,r0 while writeback targets r0
    issue(32'h8C20_0000, 32'h0000_0114);
    step();
    chk("lw0_dest", 32'(bus.dest_out), 32'd0);
    issue(32'h0000_5020, 32'h0000_0118);
    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    chk("r0_nostall", 32'(bus.stall), 32'd0);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("r0_valid", 32'(bus.valid_out), 32'd1);
    chk("r0_a",     bus.a_out,          32'h0);
    chk("r0_b",     bus.b_out,          32'h0);
    chk("r0_dest",  32'(bus.dest_out),  32'd10);

    // jump and illegal opcode
    issue(32'h0800_0010, 32'h0000_011C);
    step();
    chk("j_imm",   bus.imm_out,        32'h0000_0010);
    chk("j_dest",  32'(bus.dest_out),  32'd0);
    chk("j_itype", 32'(bus.itype_out), 32'd6);
    issue(32'h7C00_0000, 32'h0000_0120);
    step();
    chk("ill_valid", 32'(bus.valid_out), 32'd0);
    chk("ill_itype", 32'(bus.itype_out), 32'd0);

    // flushed HALT, then real HALT
    issue(32'hFC00_0000, 32'h0000_0124);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl_valid",  32'(bus.valid_out), 32'd0);
    chk("fl_halted", 32'(bus.halted),    32'd0);
    step();
    chk("h_itype",  32'(bus.itype_out), 32'd7);
    chk("h_valid",  32'(bus.valid_out), 32'd1);
    chk("h_halted", 32'(bus.halted),    32'd1);
    issue(32'h00A0_1820, 32'h0000_0128);
    wb(1'b1, 5'd9, 32'h0000_0099);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("hb_valid",  32'(bus.valid_out), 32'd0);
    chk("hb_halted", 32'(bus.halted),    32'd1);
    chk("hb_r9",     dut.rf[9],          32'h0000_0099);
    step();
    chk("hb2_valid", 32'(bus.valid_out), 32'd0);

    // async reset between edges after some live state
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_halted", 32'(bus.halted),    32'd0);
    chk("ar_valid",  32'(bus.valid_out), 32'd0);
    chk("ar_npc",    bus.npc_out,        32'h0);
    chk("ar_ir",     bus.ir_out,         32'h0);
    chk("ar_r5",     dut.rf[5],          32'h0);
    chk("ar_r9",     dut.rf[9],          32'h0);
    chk("ar_stall",  32'(bus.stall),     32'd0);
    #10;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
